fetch_decode_queue: RTL and testbench

- Elastic instruction buffer between instr_fetch and the decode stage.
- Absorbs fetch packets {instruction, pc, pcplus4} and presents them to decode with a valid/ready handshake.
- Drives fetch's enable as backpressure and discards all buffered packets when decode signals a taken branch/jump.
- Decouples cache hit latency from decode/hazard stalls.

---
 rtl/multicore_pkg.sv | 14 +
 rtl/fdq_storage.sv | 36 +++
 rtl/fetch_decode_queue.sv | 91 +++++++++
 tb/tb_fetch_decode_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the core pipeline: instruction width and the fetch packet
// carried from instr_fetch through the fetch/decode queue.
package multicore_pkg;

  localparam int INST_SIZE     = 32;
  localparam int PKT_ADDR_SIZE = 32;

  typedef struct packed {
    logic [INST_SIZE-1:0]     instruction;
    logic [PKT_ADDR_SIZE-1:0] pc;
    logic [PKT_ADDR_SIZE-1:0] pcplus4;
  } fetch_packet_t;

endpackage : multicore_pkg

// File: rtl/fdq_storage.sv
// Register array backing the fetch/decode queue: one synchronous write port,
// one asynchronous read port, every entry cleared on reset.
module fdq_storage
  import multicore_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_aclk,
  input  logic          i_areset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  fetch_packet_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fetch_packet_t o_rdata
);

  fetch_packet_t r_mem [DEPTH];

  // NOTE: the array is reset so the head outputs read zero out of reset; this
  // forces flops instead of a RAM macro, which is acceptable at this depth.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of
      // block ordering; blocking here would create simulation races.
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : fdq_storage

// File: rtl/fetch_decode_queue.sv
// Elastic buffer between instruction fetch and decode. Fetch is backpressured
// through o_fetch_en; a taken branch/jump (i_flush) discards all entries.
module fetch_decode_queue
  import multicore_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         i_aclk,
  input  logic                         i_areset_n,
  input  logic                         i_instr_valid,
  input  logic [INST_SIZE-1:0]         i_instruction,
  input  logic [ADDR_SIZE-1:0]         i_pc,
  input  logic [ADDR_SIZE-1:0]         i_pcplus4,
  output logic                         o_fetch_en,
  input  logic                         i_decode_ready,
  input  logic                         i_flush,
  output logic                         o_instr_valid,
  output logic [INST_SIZE-1:0]         o_instruction,
  output logic [ADDR_SIZE-1:0]         o_pc,
  output logic [ADDR_SIZE-1:0]         o_pcplus4,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  fetch_packet_t w_wdata;
  fetch_packet_t w_rdata;

  // Ready depends only on registered occupancy and flush, never on decode
  // readiness, so no combinational path runs from decode back into fetch.
  assign w_full        = (r_count == CW'(DEPTH));
  assign o_fetch_en    = ~w_full | i_flush;
  assign o_instr_valid = (r_count != '0);

  assign w_push = i_instr_valid & o_fetch_en & ~i_flush;
  assign w_pop  = o_instr_valid & i_decode_ready & ~i_flush;

  assign w_wdata.instruction = i_instruction;
  assign w_wdata.pc          = i_pc;
  assign w_wdata.pcplus4     = i_pcplus4;

  fdq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .i_aclk     (i_aclk),
    .i_areset_n (i_areset_n),
    .i_we       (w_push),
    .i_waddr    (r_wr_ptr),
    .i_wdata    (w_wdata),
    .i_raddr    (r_rd_ptr),
    .o_rdata    (w_rdata)
  );

  // Pointers wrap naturally since DEPTH is a power of two; the separate count
  // keeps full and empty distinguishable.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_instruction = w_rdata.instruction;
  assign o_pc          = w_rdata.pc;
  assign o_pcplus4     = w_rdata.pcplus4;
  assign o_count       = r_count;

endmodule : fetch_decode_queue

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: single packet latency, fill and
// backpressure, streaming with wrap, flush, full-with-pop and async reset.
module tb_fetch_decode_queue;
  import multicore_pkg::*;

  localparam int ADDR_SIZE = 32;
  localparam int DEPTH     = 4;
  localparam int CW        = $clog2(DEPTH+1);

  logic                 i_aclk = 1'b0;
  logic                 i_areset_n;
  logic                 i_instr_valid;
  logic [INST_SIZE-1:0] i_instruction;
  logic [ADDR_SIZE-1:0] i_pc;
  logic [ADDR_SIZE-1:0] i_pcplus4;
  logic                 o_fetch_en;
  logic                 i_decode_ready;
  logic                 i_flush;
  logic                 o_instr_valid;
  logic [INST_SIZE-1:0] o_instruction;
  logic [ADDR_SIZE-1:0] o_pc;
  logic [ADDR_SIZE-1:0] o_pcplus4;
  logic [CW-1:0]        o_count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(
    .ADDR_SIZE (ADDR_SIZE),
    .DEPTH     (DEPTH)
  ) dut (
    .i_aclk         (i_aclk),
    .i_areset_n     (i_areset_n),
    .i_instr_valid  (i_instr_valid),
    .i_instruction  (i_instruction),
    .i_pc           (i_pc),
    .i_pcplus4      (i_pcplus4),
    .o_fetch_en     (o_fetch_en),
    .i_decode_ready (i_decode_ready),
    .i_flush        (i_flush),
    .o_instr_valid  (o_instr_valid),
    .o_instruction  (o_instruction),
    .o_pc           (o_pc),
    .o_pcplus4      (o_pcplus4),
    .o_count        (o_count)
  );

  always #5 i_aclk = ~i_aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge i_aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    i_instr_valid = v;
    i_pc          = pc;
    i_pcplus4     = pc + 32'd4;
    i_instruction = 32'hA000_0000 | pc;
  endtask

  initial begin
    i_areset_n     = 1'b0;
    i_flush        = 1'b0;
    i_decode_ready = 1'b0;
    drive(1'b0, 32'h0);
    #2;
    check("rst_valid", 64'(o_instr_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_fetch_en", 64'(o_fetch_en), 64'd1);
    check("rst_instr", 64'(o_instruction), 64'd0);
    check("rst_pc", 64'(o_pc), 64'd0);
    check("rst_pcplus4", 64'(o_pcplus4), 64'd0);
    #10 i_areset_n = 1'b1;

    // Single packet: visible one cycle after push, gone the cycle after.
    i_instr_valid  = 1'b1;
    i_instruction  = 32'h0050_0093;
    i_pc           = 32'h0;
    i_pcplus4      = 32'h4;
    i_decode_ready = 1'b1;
    tick();
    i_instr_valid = 1'b0;
    #1;
    check("t1_valid", 64'(o_instr_valid), 64'd1);
    check("t1_instr", 64'(o_instruction), 64'h0050_0093);
    check("t1_pc", 64'(o_pc), 64'h0);
    check("t1_pcplus4", 64'(o_pcplus4), 64'h4);
    check("t1_count", 64'(o_count), 64'd1);
    tick();
    #1;
    check("t1_drain_valid", 64'(o_instr_valid), 64'd0);
    check("t1_drain_count", 64'(o_count), 64'd0);

    // Fill with decode stalled, fifth packet held by fetch.
    i_decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h10);
    #1;
    check("fill_count", 64'(o_count), 64'd4);
    check("fill_fetch_en", 64'(o_fetch_en), 64'd0);
    tick();
    tick();
    #1;
    check("stall_count", 64'(o_count), 64'd4);
    check("stall_pc", 64'(o_pc), 64'h0);
    i_decode_ready = 1'b1;
    #1;
    check("release_fetch_en", 64'(o_fetch_en), 64'd0);
    tick();
    #1;
    check("drain0_count", 64'(o_count), 64'd3);
    check("drain0_pc", 64'(o_pc), 64'h4);
    check("drain0_fetch_en", 64'(o_fetch_en), 64'd1);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("drain1_count", 64'(o_count), 64'd3);
    check("drain1_pc", 64'(o_pc), 64'h8);
    tick();
    #1;
    check("drain2_pc", 64'(o_pc), 64'hC);
    tick();
    #1;
    check("drain3_pc", 64'(o_pc), 64'h10);
    check("drain3_pcplus4", 64'(o_pcplus4), 64'h14);
    check("drain3_count", 64'(o_count), 64'd1);
    tick();
    #1;
    check("drain_empty", 64'(o_instr_valid), 64'd0);

    // Streaming: one in, one out per cycle, pointers wrap several times.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(4 * i));
      tick();
      #1;
      check($sformatf("stream%0d_count", i), 64'(o_count), 64'd1);
      check($sformatf("stream%0d_pc", i), 64'(o_pc), 64'(4 * i));
      check($sformatf("stream%0d_fetch_en", i), 64'(o_fetch_en), 64'd1);
    end
    drive(1'b0, 32'h0);
    tick();
    #1;
    check("stream_end_count", 64'(o_count), 64'd0);

    // Flush with three buffered entries and a packet on the input.
    i_decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h20 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h2C);
    i_flush = 1'b1;
    #1;
    check("flush_pre_count", 64'(o_count), 64'd3);
    check("flush_fetch_en", 64'(o_fetch_en), 64'd1);
    tick();
    i_flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    check("flush_count", 64'(o_count), 64'd0);
    check("flush_valid", 64'(o_instr_valid), 64'd0);
    i_decode_ready = 1'b1;
    drive(1'b1, 32'h100);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("post_flush_valid", 64'(o_instr_valid), 64'd1);
    check("post_flush_pc", 64'(o_pc), 64'h100);
    tick();
    #1;
    check("post_flush_empty", 64'(o_count), 64'd0);

    // Flush while full forces fetch enable high.
    i_decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 32'h0);
    #1;
    check("full_fetch_en", 64'(o_fetch_en), 64'd0);
    i_flush = 1'b1;
    #1;
    check("full_flush_fetch_en", 64'(o_fetch_en), 64'd1);
    tick();
    i_flush = 1'b0;
    #1;
    check("full_flush_count", 64'(o_count), 64'd0);

    // Full with decode ready: pop only, then push+pop holds at three.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      tick();
    end
    drive(1'b1, 32'h210);
    i_decode_ready = 1'b1;
    #1;
    check("fullpop_count", 64'(o_count), 64'd4);
    check("fullpop_fetch_en", 64'(o_fetch_en), 64'd0);
    tick();
    #1;
    check("fullpop1_count", 64'(o_count), 64'd3);
    check("fullpop1_pc", 64'(o_pc), 64'h204);
    tick();
    drive(1'b0, 32'h0);
    #1;
    check("fullpop2_count", 64'(o_count), 64'd3);
    check("fullpop2_pc", 64'(o_pc), 64'h208);
    tick();
    #1;
    check("midreset_pre_count", 64'(o_count), 64'd2);

    // Asynchronous reset away from any clock edge.
    i_areset_n = 1'b0;
    #1;
    check("areset_valid", 64'(o_instr_valid), 64'd0);
    check("areset_count", 64'(o_count), 64'd0);
    check("areset_fetch_en", 64'(o_fetch_en), 64'd1);
    check("areset_pc", 64'(o_pc), 64'd0);
    #10 i_areset_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not complete");
  end

endmodule : tb_fetch_decode_queue
